// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator running in the pixel-clock domain. It waits for the
// PLL lock to be stable for LOCK_STABLE consecutive cycles, then scans a
// horizontal/vertical counter pair. From the counters it produces registered
// sync, data-enable, pixel coordinates and a start-of-frame pulse for the
// pattern/framebuffer stage and the TMDS encoder. The default parameters give
// 1280x1024@60, which needs a 108 MHz pixel clock.
//
// Ports
//   clk       in   1      pixel clock (PLL clkout)
//   rst       in   1      asynchronous reset, active-high
//   pll_lock  in   1      PLL lock, asynchronous to clk
//   hs        out  1      horizontal sync, level HS_POL inside the sync region
//   vs        out  1      vertical sync, level VS_POL inside the sync region
//   de        out  1      data enable, high only in the active area
//   x         out  CNT_W  pixel column while de=1, else 0
//   y         out  CNT_W  pixel row while de=1, else 0
//   sof       out  1      one-cycle pulse on pixel (0,0) of every frame
//   running   out  1      high while the state machine is in RUN
//
// State    | meaning
// ---------+--------------------------------------------------------------
// ST_WAIT  | outputs idle; counting consecutive synchronised-lock cycles
// ST_RUN   | counters scan the raster; outputs follow them one clock later
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int   H_ACTIVE    = 1280,
  parameter int   H_FP        = 48,
  parameter int   H_SYNC      = 112,
  parameter int   H_BP        = 248,
  parameter int   V_ACTIVE    = 1024,
  parameter int   V_FP        = 1,
  parameter int   V_SYNC      = 3,
  parameter int   V_BP        = 38,
  parameter logic HS_POL      = 1'b1,
  parameter logic VS_POL      = 1'b1,
  parameter int   LOCK_STABLE = 1024,
  parameter int   CNT_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             sof,
  output logic             running
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // The stability counter never exceeds LOCK_STABLE-1, so it only needs to
  // hold that value; keep at least one bit for the LOCK_STABLE=1 case.
  localparam int ST_W = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;

  localparam logic [ST_W-1:0]  STAB_LAST = ST_W'(LOCK_STABLE - 1);
  localparam logic [ST_W-1:0]  STAB_ONE  = ST_W'(1);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic             lock_m;
  logic             lock_s;
  logic [ST_W-1:0]  stab_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic             h_in_active;
  logic             v_in_active;
  logic             de_nxt;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             sof_nxt;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  // Output decode from the current counter values; registered below, so the
  // outputs trail the counters by one clock.
  always_comb begin
    h_in_active = (h_cnt < H_ACT_END);
    v_in_active = (v_cnt < V_ACT_END);
    de_nxt      = h_in_active && v_in_active;
    hs_nxt      = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HS_POL : ~HS_POL;
    // vs is decoded from v_cnt only, so it changes when h_cnt wraps to 0.
    vs_nxt      = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VS_POL : ~VS_POL;
    sof_nxt     = (h_cnt == '0) && (v_cnt == '0);
    x_nxt       = de_nxt ? h_cnt : '0;
    y_nxt       = de_nxt ? v_cnt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_WAIT;
      stab_cnt <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      running  <= 1'b0;
      hs       <= ~HS_POL;
      vs       <= ~VS_POL;
      de       <= 1'b0;
      x        <= '0;
      y        <= '0;
      sof      <= 1'b0;
    end else begin
      case (state)
        ST_WAIT: begin
          hs  <= ~HS_POL;
          vs  <= ~VS_POL;
          de  <= 1'b0;
          x   <= '0;
          y   <= '0;
          sof <= 1'b0;
          if (lock_s) begin
            if (stab_cnt == STAB_LAST) begin
              // Start the raster at (0,0) so the first RUN cycle emits sof.
              state    <= ST_RUN;
              running  <= 1'b1;
              stab_cnt <= '0;
              h_cnt    <= '0;
              v_cnt    <= '0;
            end else begin
              stab_cnt <= stab_cnt + STAB_ONE;
            end
          end else begin
            // Any drop of the synchronised lock restarts the stability window.
            stab_cnt <= '0;
          end
        end

        ST_RUN: begin
          if (!lock_s) begin
            // Abandon the frame on the spot; relock restarts it from (0,0).
            state    <= ST_WAIT;
            running  <= 1'b0;
            stab_cnt <= '0;
            h_cnt    <= '0;
            v_cnt    <= '0;
            hs       <= ~HS_POL;
            vs       <= ~VS_POL;
            de       <= 1'b0;
            x        <= '0;
            y        <= '0;
            sof      <= 1'b0;
          end else begin
            hs  <= hs_nxt;
            vs  <= vs_nxt;
            de  <= de_nxt;
            x   <= x_nxt;
            y   <= y_nxt;
            sof <= sof_nxt;
            if (h_cnt == H_LAST) begin
              h_cnt <= '0;
              if (v_cnt == V_LAST) begin
                v_cnt <= '0;
              end else begin
                v_cnt <= v_cnt + CNT_ONE;
              end
            end else begin
              h_cnt <= h_cnt + CNT_ONE;
            end
          end
        end

        default: begin
          state    <= ST_WAIT;
          running  <= 1'b0;
          stab_cnt <= '0;
          h_cnt    <= '0;
          v_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Drives video_timing_gen with small raster parameters (H 4/1/2/1, V 3/1/1/1,
// LOCK_STABLE=4). A reference model tracks the lock history, the count of
// consecutive stable cycles and a single linear pixel position within the
// frame; expected outputs are derived from that position with plain
// arithmetic. Directed scenarios are followed by a randomised lock/reset phase.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int H_ACTIVE    = 4;
  localparam int H_FP        = 1;
  localparam int H_SYNC      = 2;
  localparam int H_BP        = 1;
  localparam int V_ACTIVE    = 3;
  localparam int V_FP        = 1;
  localparam int V_SYNC      = 1;
  localparam int V_BP        = 1;
  localparam int LOCK_STABLE = 4;
  localparam int CNT_W       = 12;
  localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME       = H_TOTAL * V_TOTAL;

  logic             clk;
  logic             rst;
  logic             pll_lock;
  logic             hs;
  logic             vs;
  logic             de;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;
  logic             sof;
  logic             running;

  video_timing_gen #(
    .H_ACTIVE    (H_ACTIVE),
    .H_FP        (H_FP),
    .H_SYNC      (H_SYNC),
    .H_BP        (H_BP),
    .V_ACTIVE    (V_ACTIVE),
    .V_FP        (V_FP),
    .V_SYNC      (V_SYNC),
    .V_BP        (V_BP),
    .HS_POL      (1'b1),
    .VS_POL      (1'b1),
    .LOCK_STABLE (LOCK_STABLE),
    .CNT_W       (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pll_lock (pll_lock),
    .hs       (hs),
    .vs       (vs),
    .de       (de),
    .x        (x),
    .y        (y),
    .sof      (sof),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit m_s1, m_s2;
  bit m_run;
  int m_streak;
  int m_pos;
  bit e_hs, e_vs, e_de, e_sof, e_run;
  int e_x, e_y;

  // Per-window statistics for the full-frame scenario
  int de_cnt, sof_cnt, hs_cnt, vs_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_idle();
    e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_sof = 1'b0; e_x = 0; e_y = 0;
  endtask

  task automatic set_pixel(input int p);
    int h, v;
    h     = p % H_TOTAL;
    v     = p / H_TOTAL;
    e_de  = (h < H_ACTIVE) && (v < V_ACTIVE);
    e_hs  = (h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC);
    e_vs  = (v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC);
    e_x   = e_de ? h : 0;
    e_y   = e_de ? v : 0;
    e_sof = (p == 0);
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_run = 1'b0; m_streak = 0; m_pos = 0;
    e_run = 1'b0;
    set_idle();
  endtask

  // One rising edge of the model; pll_lock is stable around the edge.
  task automatic model_edge();
    bit ls;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = pll_lock;
    if (m_run) begin
      if (!ls) begin
        m_run = 1'b0;
        m_streak = 0;
        set_idle();
      end else begin
        set_pixel(m_pos);
        m_pos = (m_pos + 1) % FRAME;
      end
    end else begin
      set_idle();
      if (ls) begin
        m_streak++;
        if (m_streak == LOCK_STABLE) begin
          m_run = 1'b1;
          m_streak = 0;
          m_pos = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
    e_run = m_run;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".hs"},      32'(hs),      32'(e_hs));
    chk({tag, ".vs"},      32'(vs),      32'(e_vs));
    chk({tag, ".de"},      32'(de),      32'(e_de));
    chk({tag, ".x"},       32'(x),       32'(e_x));
    chk({tag, ".y"},       32'(y),       32'(e_y));
    chk({tag, ".sof"},     32'(sof),     32'(e_sof));
    chk({tag, ".running"}, 32'(running), 32'(e_run));
  endtask

  // Advance one clock, update the model, sample 1 ns after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_outs(tag);
    if (de)  de_cnt++;
    if (sof) sof_cnt++;
    if (hs)  hs_cnt++;
    if (vs)  vs_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    pll_lock = 1'b0;
    model_reset();
    #2;
    check_outs("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: lock held low, everything idle
    for (int i = 0; i < 50; i++) step("nolock");
    chk("nolock_running", 32'(running), 32'd0);

    // 2: lock raised just before edge 1
    pll_lock = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step("startup");
      if (i == 5) chk("startup_run_e5", 32'(running), 32'd0);
      if (i == 6) begin
        chk("startup_run_e6", 32'(running), 32'd1);
        chk("startup_sof_e6", 32'(sof), 32'd0);
      end
      if (i == 7) begin
        chk("startup_sof_e7", 32'(sof), 32'd1);
        chk("startup_de_e7",  32'(de),  32'd1);
        chk("startup_xy_e7",  32'({x, y}), 32'd0);
      end
    end

    // 3: one full frame after the first sof
    de_cnt = 0; sof_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < FRAME; i++) step("frame");
    chk("frame_de_total",  32'(de_cnt),  32'd12);
    chk("frame_hs_total",  32'(hs_cnt),  32'd12);
    chk("frame_vs_total",  32'(vs_cnt),  32'd8);
    chk("frame_sof_total", 32'(sof_cnt), 32'd1);
    chk("frame_sof_at_48", 32'(sof),     32'd1);

    // Back to WAIT before the glitch scenario
    pll_lock = 1'b0;
    for (int i = 0; i < 4; i++) step("drop_to_wait");
    chk("wait_running", 32'(running), 32'd0);

    // 4: one-clock glitch reaching the counter while stab_cnt=2
    pll_lock = 1'b1;                        // before e1
    step("glitch"); step("glitch");         // e1, e2
    pll_lock = 1'b0;                        // before e3
    step("glitch");                         // e3
    pll_lock = 1'b1;                        // before e4
    for (int i = 4; i <= 9; i++) begin
      step("glitch");
      if (i == 6) chk("glitch_no_run_e6", 32'(running), 32'd0);
      if (i == 8) chk("glitch_no_run_e8", 32'(running), 32'd0);
      if (i == 9) chk("glitch_run_e9",    32'(running), 32'd1);
    end

    // 5: lock loss at h_cnt=2, v_cnt=1 (linear position 10)
    for (int i = 0; i < 10; i++) step("pre_drop");
    pll_lock = 1'b0;
    step("drop"); step("drop");
    chk("drop_run_e2", 32'(running), 32'd1);
    step("drop");
    chk("drop_idle_run", 32'(running), 32'd0);
    chk("drop_idle_de",  32'(de),      32'd0);
    pll_lock = 1'b1;
    for (int i = 0; i < 7; i++) step("relock");
    chk("relock_sof", 32'(sof), 32'd1);
    chk("relock_xy",  32'({x, y}), 32'd0);

    // 6: asynchronous reset mid-line
    for (int i = 0; i < 13; i++) step("pre_rst");
    rst = 1'b1;
    model_reset();
    #1;
    check_outs("rst_async");
    chk("rst_async_hs", 32'(hs), 32'd0);
    step("rst_hold");
    rst = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step("rst_restart");
      if (i == 5) chk("restart_run_e5", 32'(running), 32'd0);
      if (i == 6) chk("restart_run_e6", 32'(running), 32'd1);
      if (i == 7) chk("restart_sof_e7", 32'(sof),     32'd1);
    end

    // Randomised lock behaviour with occasional resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) begin
        rst = 1'b1;
        model_reset();
        #1;
        check_outs("rnd_rst");
        step("rnd_rst_hold");
        rst = 1'b0;
      end else begin
        if (pll_lock) begin
          if (r < 20) pll_lock = 1'b0;
        end else begin
          if (r < 300) pll_lock = 1'b1;
        end
        step("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
